// File: rtl/dual_asy_rd_seq.sv
// Read-burst sequencer for the dual_asy RAM read port. It issues len single-word
// reads from base and streams the returned words out through a 4-entry valid/ready buffer.
module dual_asy_rd_seq #(
  parameter int wi  = 8,
  parameter int dep = 16,
  parameter int add = 4
) (
  input  logic           rd_clk,
  input  logic           rst,
  input  logic           start,
  input  logic [add-1:0] base,
  input  logic [add:0]   len,
  output logic           busy,
  output logic           done,
  output logic           rd,
  output logic [add-1:0] ra,
  input  logic [wi-1:0]  dout,
  output logic [wi-1:0]  m_data,
  output logic           m_valid,
  input  logic           m_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t         state, state_nxt;
  logic [add-1:0] base_q;
  logic [add:0]   len_q, len_eff;
  logic [add:0]   icnt, ocnt;
  logic           pend;
  logic [wi-1:0]  buf_mem [4];
  logic [1:0]     head, tail;
  logic [2:0]     bcnt;
  logic           push, pop, issue, room;
  logic [add-1:0] issue_addr;

  // Lengths above the RAM depth would reread addresses, so they are clamped.
  assign len_eff = (len > (add+1)'(dep)) ? (add+1)'(dep) : len;

  // Words already buffered plus reads still in flight must fit in the buffer.
  assign room = (bcnt + 3'(rd) + 3'(pend)) < 3'd4;

  assign push = pend;
  assign pop  = m_valid & m_ready;

  assign m_valid = (bcnt != 3'd0);
  assign m_data  = m_valid ? buf_mem[head] : '0;
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);

  assign issue_addr = (state == IDLE) ? base : base_q + icnt[add-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_eff == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt = RUN;
            issue     = 1'b1;
          end
        end
      end
      RUN: begin
        if (icnt == len_q) state_nxt = DRAIN;
        else               issue     = room;
      end
      DRAIN: begin
        if (pop && (ocnt + (add+1)'(1)) == len_q) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      icnt   <= '0;
      ocnt   <= '0;
      rd     <= 1'b0;
      ra     <= '0;
      pend   <= 1'b0;
      head   <= '0;
      tail   <= '0;
      bcnt   <= '0;
    end else begin
      state <= state_nxt;
      rd    <= issue;
      pend  <= rd;
      if (issue) ra <= issue_addr;

      if (state == IDLE) begin
        if (start) begin
          base_q <= base;
          len_q  <= len_eff;
          icnt   <= issue ? (add+1)'(1) : '0;
          ocnt   <= '0;
        end
      end else begin
        if (issue) icnt <= icnt + (add+1)'(1);
        if (pop)   ocnt <= ocnt + (add+1)'(1);
      end

      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;
      case ({push, pop})
        2'b10:   bcnt <= bcnt + 3'd1;
        2'b01:   bcnt <= bcnt - 3'd1;
        default: bcnt <= bcnt;
      endcase
    end
  end

  // NOTE: buffer storage is not reset; bcnt marks which entries are live and m_data is gated to 0 when empty.
  always_ff @(posedge rd_clk) begin
    if (push) buf_mem[tail] <= dout;
  end

endmodule

// File: doc/dual_asy_rd_seq.md
# dual_asy_rd_seq

Read-burst sequencer on the read port of the `dual_asy` dual-port RAM (wi=8, dep=16, add=4), clocked by `rd_clk`. On `start` it issues `len` consecutive single-word reads from `base` and drives the `rd`/`ra` pins of the RAM. It captures each `dout` word one cycle after the RAM samples the request. It then presents the words in order on a valid/ready stream, with a 4-entry output buffer, so the stream runs at full rate under backpressure.

## Interface
- `wi`, 8, data width; equals RAM `wi`
- `dep`, 16, RAM depth; equals 2**`add`
- `add`, 4, address width; equals RAM `add`
- `rd_clk`  in  1  read-domain clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `start`  in  1  burst request; sampled only when `busy`=0
- `base`  in  `add`  first read address, captured with `start`
- `len`  in  `add`+1  burst length 0..`dep`, captured with `start`
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse when the last word is accepted
- `rd`  out  1  RAM read enable (registered)
- `ra`  out  `add`  RAM read address (registered)
- `dout`  in  `wi`  RAM read data; valid in the cycle after a cycle with `rd`=1
- `m_data`  out  `wi`  stream data = buffer head
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready; a transfer occurs on `m_valid`&`m_ready` at an edge

## Operation
- States:
  - IDLE: wait for `start`. On `start`=1, capture `base`/`len`. If `len`=0, go to FIN. Otherwise go to RUN.
  - RUN: issue reads until `len` requests are issued, then go to DRAIN.
  - DRAIN: wait until all `len` words are transferred out, then go to FIN.
  - FIN: one cycle with `done`=1, then go to IDLE.
- `busy` = state != IDLE. It is high for the whole burst, including the FIN cycle.
- `start` is ignored while `busy`=1. `base`/`len` changes mid-burst have no effect.
- Issue counter `icnt` (`add`+1 bits) counts requests issued.
- `ra` = `base` + `icnt` truncated to `add` bits. Address wraps from `dep`-1 to 0, so base=14, len=4 reads 14,15,0,1.
- `pend` register = `rd` delayed one cycle. When `pend`=1, `dout` is pushed into the 4-entry buffer at that edge.
- Issue rule: at each edge in RUN, `rd`<=1 iff `icnt`<`len` and (`bcnt` + `rd` + `pend`) < 4. Here `bcnt` is the buffer occupancy before that edge.
  - This rule guarantees the buffer never overflows. No data loss under any `m_ready` pattern.
- A push and a pop in the same edge leave `bcnt` unchanged. The push writes the tail; the pop advances the head.
- `m_valid` = `bcnt`!=0. `m_data` holds the head stably while `m_valid`=1 and `m_ready`=0.
- The output counter `ocnt` increments on each transfer. When `ocnt` reaches `len` in DRAIN, go to FIN.
- Reset (asynchronous, any state, mid-burst included) takes effect immediately and discards all buffered and in-flight data:
  - state=IDLE
  - `busy`=0, `done`=0, `rd`=0, `ra`=0
  - `pend`=0, `bcnt`=0, `m_valid`=0, `m_data`=0
  - `icnt`=0, `ocnt`=0

## Timing
- Edge E0 samples `start`=1 with `len`>0:
  - `busy`=1 and `rd`=1, `ra`=`base` in the cycle after E0.
  - The RAM samples the request at E1.
  - `pend`=1 and `dout` is valid after E1.
  - The word is pushed at E2. `m_valid`=1 after E2.
  - Start-to-first-`m_valid` latency: 3 cycles.
- With `m_ready` held 1, reads issue every cycle and `m_valid` stays 1 for `len` consecutive cycles.
  - The last transfer occurs at edge E(`len`+2).
  - `done`=1 in the following cycle. `busy`=0 one cycle after that.
- `len`=0: `busy`=1 and `done`=1 in the cycle after E0, with no `rd` pulse. `busy`=0 after the next edge.
- A new `start` is accepted at the first edge where `busy`=0.
- If `m_ready`=0, issue stops once `bcnt`+`rd`+`pend` reaches 4. Issue resumes the edge after a pop frees a slot.

## Test plan
- Reset, preload RAM addr 0..3 = 8'h11,8'h22,8'h33,8'h44, `m_ready`=1, start base=0 len=4 -> `m_data` 11,22,33,44 on 4 consecutive cycles. First `m_valid` 3 cycles after start. `done` 1 cycle after the last transfer.
- base=14 len=4, mem[14]=A5, mem[15]=5A, mem[0]=01, mem[1]=02 -> `ra` sequence 14,15,0,1. Output A5,5A,01,02.
- len=16, `m_ready` held 0 for 10 cycles, then 1 -> exactly 4 words buffered, at most 4 `rd` pulses before release. All 16 words delivered in address order with no loss. `m_data` stable while stalled.
- `m_ready` random 50%, len=16, random RAM contents -> the scoreboard matches all 16 words in order. `bcnt`≤4 at all times.
- len=0 -> no `rd`. `done` pulse 1 cycle after start. A `start` asserted during `busy` is ignored: no extra reads, `base` not recaptured.
- `rst`=0 asserted asynchronously mid-burst (after 5 transfers of 16) -> all outputs 0 immediately. After release, a new start base=3 len=2 returns mem[3],mem[4] only.
